// File: rtl/register_file.sv
// 2^ADDR_WIDTH x DATA_WIDTH register file: r0 is hardwired to zero, reads are combinational with write bypass.
// A per-register pending scoreboard raises stall while a used source operand awaits writeback.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] readAddrA,
  input  logic [ADDR_WIDTH-1:0] readAddrB,
  input  logic                  readEnA,
  input  logic                  readEnB,
  output logic [DATA_WIDTH-1:0] readDataA,
  output logic [DATA_WIDTH-1:0] readDataB,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  issueEnable,
  input  logic [ADDR_WIDTH-1:0] issueAddr,
  output logic                  pendingA,
  output logic                  pendingB,
  output logic                  stall
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;

  logic wr_ok;
  logic wr_hit_a;
  logic wr_hit_b;
  logic issue_ok;

  assign wr_ok    = writeEnable && (writeAddr != '0);
  // Bypass is suppressed while reset is held so both ports read zero.
  assign wr_hit_a = rst && wr_ok && (writeAddr == readAddrA);
  assign wr_hit_b = rst && wr_ok && (writeAddr == readAddrB);

  always_comb begin
    readDataA = '0;
    if (readAddrA != '0) begin
      readDataA = wr_hit_a ? writeData : regs_q[readAddrA];
    end
  end

  always_comb begin
    readDataB = '0;
    if (readAddrB != '0) begin
      readDataB = wr_hit_b ? writeData : regs_q[readAddrB];
    end
  end

  assign pendingA = pend_q[readAddrA] & ~(writeEnable && (writeAddr == readAddrA));
  assign pendingB = pend_q[readAddrB] & ~(writeEnable && (writeAddr == readAddrB));
  assign stall    = (readEnA & pendingA) | (readEnB & pendingB);
  assign issue_ok = issueEnable && !stall && (issueAddr != '0);

  // Clear before set so a new producer supersedes the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (writeEnable) begin
      pend_d[writeAddr] = 1'b0;
    end
    if (issue_ok) begin
      pend_d[issueAddr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      if (wr_ok) begin
        regs_q[writeAddr] <= writeData;
      end
    end
  end

endmodule

// File: doc/register_file.md
# register_file

MIPS general-purpose register file with scoreboard: the read-side counterpart to the pipeline `Register` stages. It holds 32 architectural registers. The writeback stage writes into it. The decode stage reads two source operands from it combinationally. A per-register pending scoreboard tracks in-flight destinations and raises `stall` when a source operand is still being produced.

## Interface
- `DATA_WIDTH`, default 32: register width in bits.
- `ADDR_WIDTH`, default 5: register index width; depth is 2^ADDR_WIDTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `readAddrA` input ADDR_WIDTH: source operand A index.
- `readAddrB` input ADDR_WIDTH: source operand B index.
- `readEnA` input 1: operand A is used by the decoding instruction.
- `readEnB` input 1: operand B is used by the decoding instruction.
- `readDataA` output DATA_WIDTH: operand A value, combinational.
- `readDataB` output DATA_WIDTH: operand B value, combinational.
- `writeEnable` input 1: writeback valid.
- `writeAddr` input ADDR_WIDTH: writeback destination index.
- `writeData` input DATA_WIDTH: writeback value.
- `issueEnable` input 1: decoding instruction issues this cycle and will write `issueAddr`.
- `issueAddr` input ADDR_WIDTH: destination of the issuing instruction.
- `pendingA` output 1: operand A still awaits writeback.
- `pendingB` output 1: operand B still awaits writeback.
- `stall` output 1: decode must hold; `(readEnA & pendingA) | (readEnB & pendingB)`.

## Operation
- Storage: 2^ADDR_WIDTH x DATA_WIDTH registers. Index 0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0.
  - Index 0 is never pending.
- Write: on the rising edge with `writeEnable`=1 and `writeAddr`≠0, `reg[writeAddr]` ← `writeData`.
- Read: `readDataX` = `reg[readAddrX]`, combinational.
- Write-to-read bypass: if `writeEnable`=1, `writeAddr`=`readAddrX` and `writeAddr`≠0, then `readDataX` = `writeData` in the same cycle.
- Scoreboard: one `pending` bit per register.
  - Set on the edge where an issue is accepted (`issueEnable`=1 and `stall`=0) with `issueAddr`≠0.
  - Cleared on the edge where `writeEnable`=1 for that index.
  - If the same index is set and cleared on one edge, set wins: the new producer supersedes the retiring one.
- `pendingX` = `pending[readAddrX]` & ~(`writeEnable` & `writeAddr`=`readAddrX`). A same-cycle writeback satisfies the operand via the bypass.
- Issue gating: `issueEnable` asserted while `stall`=1 is ignored. The scoreboard is unchanged.
- Writeback to a non-pending index is legal: data is written, the pending bit stays 0.

## Timing
- Reset (`rst`=0, asynchronous, takes effect without a clock edge):
  - All registers become 0 and all pending bits become 0.
  - Hence `readDataA`=`readDataB`=0, `pendingA`=`pendingB`=0, `stall`=0 while held.
- Reset deassertion is synchronized externally. The first state update is on the first rising edge with `rst`=1.
- Reset asserted mid-operation discards in-flight writes and the scoreboard immediately.
- Read latency is 0 cycles (combinational). Write latency is 1 edge, with the bypass covering the write cycle.
- `stall` and `pendingX` are combinational from the read addresses, the enables and the write port. They carry no registered delay.
- Producer-to-consumer: issue at edge N sets pending. A consumer reading that index stalls until the cycle in which the writeback is presented. In that cycle `stall`=0 and the data is bypassed.

## Test plan
- Reset: hold `rst`=0 for 400 ns with arbitrary inputs.
  - Required: both read ports return 0; `stall`=0.
  - After release, read all 32 indices -> 0.
- Write/read: write 0x1234_5678 to r5, then read A=r5, B=r0 next cycle.
  - Required: A=0x1234_5678, B=0.
  - Then write 0xFFFF_FFFF to r0; r0 still reads 0.
- Bypass: in the same cycle, write r7=0xDEAD_BEEF and read A=r7 (r7 previously 0).
  - Required: A=0xDEAD_BEEF combinationally; r7 holds it after the edge.
- Scoreboard: issue to r9, then read A=r9 with `readEnA`=1.
  - Required: `stall`=1 and `pendingA`=1 every cycle until writeback r9=0x42 is presented.
  - In the writeback cycle: `stall`=0 and A=0x42.
  - With `readEnA`=0 the same sequence gives `stall`=0.
- Simultaneous set/clear: on one edge, write back r3 and issue to r3.
  - Required: pending[r3]=1 afterward; r3 holds the written data; a following read of r3 stalls.
- Gated issue and reset mid-flight:
  - Issue to r4 while `stall`=1 -> r4 not pending.
  - Pend r6, then pulse `rst`=0 -> `pendingA` for r6 drops to 0 at once and r6 reads 0.
